// File: rtl/sw_key_pkg.sv
// Shared definitions for the switch/button peripheral:
// status-word field layout used by RTL, software and the bench.
package sw_key_pkg;

  localparam int SW_LSB  = 0;
  localparam int SW_W    = 16;
  localparam int BTN_LSB = 16;
  localparam int BTN_W   = 5;
  localparam int CAP_LSB = 21;
  localparam int CAP_W   = 5;
  localparam int IN_W    = SW_W + BTN_W;
  localparam int CNT_W   = 24;

  function automatic logic [31:0] status_word(
    input logic [SW_W-1:0]  s,
    input logic [BTN_W-1:0] b,
    input logic [CAP_W-1:0] c
  );
    return {6'b0, c, b, s};
  endfunction

endpackage

// File: rtl/sw_key_debounce.sv
// One input bit: 2-flop synchronizer followed by a
// two-sample debouncer advanced by the shared tick.
module debounce_bit (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_stable
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_stable;

  // Bring the asynchronous input into the clock domain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after two agreeing tick samples.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev   <= 1'b0;
      r_stable <= 1'b0;
    end else if (i_tick) begin
      r_prev <= r_sync2;
      if (r_sync2 == r_prev)
        r_stable <= r_sync2;
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/sw_key.sv
// Switch/button peripheral: debounced inputs, sticky
// button captures with write-1-to-clear, registered read port.
module sw_key
  import sw_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic        sck,
  input  logic        rst,
  input  logic        cs_n,
  input  logic        rw,
  input  logic [31:0] mosi,
  output logic [31:0] miso,
  input  logic [15:0] sw,
  input  logic [4:0]  btn
);

  localparam logic [CNT_W-1:0] TICK_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [BTN_W-1:0] r_btn_dly;
  logic [CAP_W-1:0] r_cap;
  logic [31:0]      r_miso;

  logic             w_tick;
  logic [IN_W-1:0]  w_raw;
  logic [IN_W-1:0]  w_stable;
  logic [SW_W-1:0]  w_sw_st;
  logic [BTN_W-1:0] w_btn_st;
  logic [BTN_W-1:0] w_rise;
  logic [CAP_W-1:0] w_clr;
  logic             w_wr;
  logic             w_rd;
  logic [31:0]      w_status;
  logic             w_unused;

  assign w_tick = (r_cnt == TICK_LAST);
  assign w_raw  = {btn, sw};

  // Free-running sample-period counter shared by every bit.
  always_ff @(posedge sck) begin
    if (rst)
      r_cnt <= '0;
    else if (w_tick)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

  for (genvar i = 0; i < IN_W; i++) begin : g_db
    debounce_bit u_db (
      .i_clk    (sck),
      .i_rst    (rst),
      .i_tick   (w_tick),
      .i_raw    (w_raw[i]),
      .o_stable (w_stable[i])
    );
  end

  assign w_sw_st  = w_stable[SW_LSB +: SW_W];
  assign w_btn_st = w_stable[BTN_LSB +: BTN_W];
  assign w_rise   = w_btn_st & ~r_btn_dly;

  assign w_wr  = ~cs_n & rw;
  assign w_rd  = ~cs_n & ~rw;
  assign w_clr = w_wr ? mosi[CAP_LSB +: CAP_W] : '0;

  assign w_unused = ^{mosi[31:CAP_LSB+CAP_W],
                      mosi[CAP_LSB-1:0]};

  assign w_status = status_word(w_sw_st, w_btn_st, r_cap);

  // Sticky rising-edge capture; a new capture beats a clear.
  always_ff @(posedge sck) begin
    if (rst) begin
      r_btn_dly <= '0;
      r_cap     <= '0;
    end else begin
      r_btn_dly <= w_btn_st;
      r_cap     <= (r_cap & ~w_clr) | w_rise;
    end
  end

  // Read data register, loaded only on a read cycle.
  always_ff @(posedge sck) begin
    if (rst)
      r_miso <= '0;
    else if (w_rd)
      r_miso <= w_status;
  end

  assign miso = r_miso;

endmodule
